store_align: RTL and testbench

STORE_ALIGN -- requirements
Module: store_align

---
 rtl/isa_shared_pkg.sv | 19 +
 rtl/store_lane_gen.sv | 29 ++
 rtl/store_align.sv | 99 +++++++++
 tb/tb_store_align.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/isa_shared_pkg.sv
// Shared store-size encodings and the store-align FSM state type.
package isa_shared;

    localparam logic [2:0] ST_B = 3'b000;
    localparam logic [2:0] ST_H = 3'b001;
    localparam logic [2:0] ST_W = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } st_state_e;

    function automatic logic st_size_legal(input logic [2:0] size);
        return (size == ST_B) || (size == ST_H) || (size == ST_W);
    endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Places store data into byte lanes across a two-word window and builds the matching strobes.
module store_lane_gen
    import isa_shared::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    input  logic [31:0] data,
    output logic [63:0] shifted,
    output logic [7:0]  strobe
);

    logic [63:0] dz;
    logic [7:0]  st;

    always_comb begin
        dz = '0;
        st = '0;
        case (size)
            ST_B: begin dz = {56'd0, data[7:0]};  st = 8'h01; end
            ST_H: begin dz = {48'd0, data[15:0]}; st = 8'h03; end
            ST_W: begin dz = {32'd0, data};       st = 8'h0F; end
            default: begin dz = '0; st = '0; end
        endcase
    end

    assign shifted = dz << {off, 3'b000};
    assign strobe  = st << off;

endmodule

// File: rtl/store_align.sv
// Converts a RISC-V store of any alignment into one or two word-aligned bus write beats.
module store_align
    import isa_shared::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [2:0]            req_size,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    output logic                  done,
    output logic                  err
);

    st_state_e             state;
    logic [ADDR_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] d_q;
    logic [2:0]            s_q;
    logic [63:0]           shifted;
    logic [7:0]            strobe;
    logic [ADDR_WIDTH-1:0] base;
    logic                  beat1;

    store_lane_gen u_lane (
        .off     (a_q[1:0]),
        .size    (s_q),
        .data    (d_q),
        .shifted (shifted),
        .strobe  (strobe)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            d_q       <= '0;
            s_q       <= '0;
            req_ready <= 1'b1;
            mem_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    a_q       <= req_addr;
                    d_q       <= req_data;
                    s_q       <= req_size;
                    req_ready <= 1'b0;
                    if (st_size_legal(req_size)) begin
                        state     <= BEAT0;
                        mem_valid <= 1'b1;
                    end else begin
                        state <= RESP;
                        err   <= 1'b1;
                    end
                end
                // Any strobe bit past lane 3 means the store crosses into the next word.
                BEAT0: if (mem_ready) begin
                    if (|strobe[7:4]) begin
                        state <= BEAT1;
                    end else begin
                        state     <= RESP;
                        mem_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                BEAT1: if (mem_ready) begin
                    state     <= RESP;
                    mem_valid <= 1'b0;
                    done      <= 1'b1;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Beat payload is derived only from latched state, so it holds while the bus stalls.
    assign beat1     = (state == BEAT1);
    assign base      = {a_q[ADDR_WIDTH-1:2], 2'b00};
    assign mem_addr  = beat1 ? base + ADDR_WIDTH'(4) : base;
    assign mem_wdata = !mem_valid ? '0 : beat1 ? shifted[63:32] : shifted[31:0];
    assign mem_wstrb = !mem_valid ? '0 : beat1 ? strobe[7:4]    : strobe[3:0];

endmodule

// File: tb/tb_store_align.sv
// Table-driven bench for store_align with a beat scoreboard and hand-written reset corner case.
module tb_store_align;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [2:0]  req_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        done;
    logic        err;

    store_align #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  size;
        int          stall;
        int          nb;
        beat_t       b0;
        beat_t       b1;
    } vec_t;

    beat_t exp_q[$];
    vec_t  vt[12];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int    sc, cyc, seen, exp_cyc;
        beat_t e;
        seen = 0;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        chk($sformatf("v%0d ready_before", idx), req_ready, 1);
        if (v.nb >= 1) exp_q.push_back(v.b0);
        if (v.nb == 2) exp_q.push_back(v.b1);
        exp_cyc = (v.nb == 0) ? 1 : v.nb * (v.stall + 1) + 1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = v.addr; req_data = v.data; req_size = v.size;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        sc = 0; cyc = 1;
        while (cyc <= 40 && !seen) begin
            @(negedge clk);
            if (done || err) begin
                seen = 1;
                chk($sformatf("v%0d done_cycle", idx), 64'(cyc), 64'(exp_cyc));
                chk($sformatf("v%0d done_err", idx), {done, err}, (v.nb == 0) ? 2'b01 : 2'b10);
            end
            if (mem_valid) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("v%0d unexpected_beat", idx), mem_valid, 0);
                end else begin
                    e = exp_q[0];
                    chk($sformatf("v%0d addr", idx),  mem_addr,  e.addr);
                    chk($sformatf("v%0d wdata", idx), mem_wdata, e.wdata);
                    chk($sformatf("v%0d wstrb", idx), mem_wstrb, e.wstrb);
                    if (sc < v.stall) begin
                        mem_ready = 1'b0;
                        sc++;
                    end else begin
                        mem_ready = 1'b1;
                        sc = 0;
                        void'(exp_q.pop_front());
                    end
                end
            end
            cyc++;
        end
        if (!seen) chk($sformatf("v%0d timeout", idx), 0, 1);
        chk($sformatf("v%0d beats_left", idx), 64'(exp_q.size()), 0);
        exp_q.delete();
        @(negedge clk);
        chk($sformatf("v%0d pulse_end", idx), {done, err, mem_valid}, 3'b000);
        chk($sformatf("v%0d ready_after", idx), req_ready, 1);
        mem_ready = 1'b0;
    endtask

    function automatic beat_t bt(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        beat_t b;
        b.addr = a; b.wdata = d; b.wstrb = s;
        return b;
    endfunction

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz,
                                input int st, input int nb, input beat_t b0, input beat_t b1);
        vec_t v;
        v.addr = a; v.data = d; v.size = sz; v.stall = st; v.nb = nb; v.b0 = b0; v.b1 = b1;
        return v;
    endfunction

    initial begin
        beat_t nob;
        int    bad_seen;
        nob = bt(32'h0, 32'h0, 4'h0);
        vt[0]  = mk(32'h0000_0100, 32'hDEAD_BEEF, 3'b010, 0, 1, bt(32'h100, 32'hDEAD_BEEF, 4'hF), nob);
        vt[1]  = mk(32'h0000_0103, 32'hFFFF_FFA5, 3'b000, 0, 1, bt(32'h100, 32'hA500_0000, 4'h8), nob);
        vt[2]  = mk(32'h0000_0103, 32'h0000_1234, 3'b001, 0, 2, bt(32'h100, 32'h3400_0000, 4'h8),
                    bt(32'h104, 32'h0000_0012, 4'h1));
        vt[3]  = mk(32'h0000_0102, 32'h1234_5678, 3'b010, 3, 2, bt(32'h100, 32'h5678_0000, 4'hC),
                    bt(32'h104, 32'h0000_1234, 4'h3));
        vt[4]  = mk(32'h0000_0100, 32'hFFFF_FFFF, 3'b011, 0, 0, nob, nob);
        vt[5]  = mk(32'h0000_0001, 32'h1234_5678, 3'b000, 0, 1, bt(32'h000, 32'h0000_7800, 4'h2), nob);
        vt[6]  = mk(32'h0000_0002, 32'hABCD_EF01, 3'b001, 0, 1, bt(32'h000, 32'hEF01_0000, 4'hC), nob);
        vt[7]  = mk(32'hFFFF_FFFE, 32'hAABB_CCDD, 3'b010, 0, 2, bt(32'hFFFF_FFFC, 32'hCCDD_0000, 4'hC),
                    bt(32'h0000_0000, 32'h0000_AABB, 4'h3));
        vt[8]  = mk(32'h0000_0203, 32'h1122_3344, 3'b010, 0, 2, bt(32'h200, 32'h4400_0000, 4'h8),
                    bt(32'h204, 32'h0011_2233, 4'h7));
        vt[9]  = mk(32'h0000_0040, 32'h0000_0001, 3'b111, 0, 0, nob, nob);
        vt[10] = mk(32'h0000_0001, 32'h5555_CAFE, 3'b001, 1, 1, bt(32'h000, 32'h00CA_FE00, 4'h6), nob);
        vt[11] = mk(32'h0000_0000, 32'h0000_00FF, 3'b000, 2, 1, bt(32'h000, 32'h0000_00FF, 4'h1), nob);

        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", {req_ready, mem_valid, done, err}, 4'b1000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_state", {req_ready, mem_valid, done, err}, 4'b1000);

        for (int i = 0; i < 12; i++) run_vec(vt[i], i);

        // Reset while the second beat of a split store is stalled.
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 32'h103; req_data = 32'h1234; req_size = 3'b001; mem_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_seq beat0_addr", {mem_valid, mem_addr}, {1'b1, 32'h100});
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("rst_seq beat1_addr", {mem_valid, mem_addr, mem_wstrb}, {1'b1, 32'h104, 4'h1});
        @(negedge clk);
        chk("rst_seq beat1_held", {mem_valid, mem_wdata}, {1'b1, 32'h12});
        #2 rst_n = 1'b0;
        #1;
        chk("rst_seq valid_drop", {mem_valid, done, err}, 3'b000);
        bad_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (done || err || mem_valid) bad_seen = 1;
        end
        rst_n = 1'b1;
        mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done || err || mem_valid) bad_seen = 1;
        end
        chk("rst_seq no_done", bad_seen, 0);
        chk("rst_seq ready", req_ready, 1);
        mem_ready = 1'b0;
        run_vec(vt[0], 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
